// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants for the single-clock FIFO family: default
//                data/address widths, read-mode encodings and a helper that
//                validates the almost-full / almost-empty margins.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DSIZE_DEFAULT = 8;
    localparam int FIFO_ASIZE_DEFAULT = 4;

    // Read-mode encodings for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // A margin is usable only when it lies strictly inside 0..DEPTH
    function automatic bit fifo_margin_ok(input int margin, input int asize);
        return (margin >= 1) && (margin <= (1 << asize) - 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_sync_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_ram
//  Description : Simple dual-port (1W1R) synchronous RAM, 2**ASIZE x DSIZE,
//                with a registered read port gated by a read enable.
//                A read of the address being written in the same cycle
//                returns the old contents.
//  Ports       : clk       - clock
//                rst       - synchronous clear of the read register only
//                i_we      - write enable
//                i_waddr   - write address
//                i_wdata   - write data
//                i_re      - read enable (loads the read register)
//                i_raddr   - read address
//                o_rdata   - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE_DEFAULT,
    parameter int ASIZE = FIFO_ASIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int C_DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [C_DEPTH];
    logic [DSIZE-1:0] r_rdata;

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : fifo_sync_ram
`default_nettype wire

// File: rtl/fifo_sync_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_fwft
//  Description : Single-clock FIFO with exact flags, programmable almost
//                thresholds, fill level, sticky overflow/underflow,
//                synchronous flush and selectable standard or
//                first-word-fall-through read mode.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                clr               - synchronous flush (same effect as rst)
//                wdata, winc       - write data / write request
//                wfull             - FIFO holds DEPTH entries
//                walmost_full      - level >= DEPTH-AF_MARGIN
//                rinc              - read request (FWFT: pop head)
//                rdata, rvalid     - registered read data / valid
//                rempty            - nothing to read
//                ralmost_empty     - level <= AE_MARGIN
//                level             - entry count 0..DEPTH
//                overflow          - sticky: write rejected because full
//                underflow         - sticky: read while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter int DSIZE     = FIFO_DSIZE_DEFAULT,
    parameter int ASIZE     = FIFO_ASIZE_DEFAULT,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   level,
    output logic             overflow,
    output logic             underflow
);

    localparam int             C_DEPTH    = 1 << ASIZE;
    localparam int             C_LW       = ASIZE + 1;
    localparam logic [ASIZE:0] C_FULL_LVL = C_LW'(C_DEPTH);
    localparam logic [ASIZE:0] C_AF_LVL   = C_LW'(C_DEPTH - AF_MARGIN);
    localparam logic [ASIZE:0] C_AE_LVL   = C_LW'(AE_MARGIN);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (!fifo_margin_ok(AF_MARGIN, ASIZE)) begin : g_bad_af_margin
            $error("fifo_sync_fwft: AF_MARGIN must be in 1..DEPTH-1");
        end
        if (!fifo_margin_ok(AE_MARGIN, ASIZE)) begin : g_bad_ae_margin
            $error("fifo_sync_fwft: AE_MARGIN must be in 1..DEPTH-1");
        end
        if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
            $error("fifo_sync_fwft: FWFT must be FIFO_STD or FIFO_FWFT");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------------
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_flush;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;

    // Mode-specific RAM control, driven from the generate branches
    logic             w_ram_we;
    logic             w_ram_re;
    logic [ASIZE-1:0] w_ram_raddr;
    logic [DSIZE-1:0] w_ram_q;
    logic             w_rptr_inc;

    assign w_flush = rst | clr;
    assign w_full  = (r_level == C_FULL_LVL);
    assign w_rd_ok = rinc & ~w_empty;
    // A full FIFO still accepts a write when a read frees a slot on the same edge
    assign w_wr_ok = winc & (~w_full | w_rd_ok);

    fifo_sync_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk     (clk),
        .rst     (w_flush),
        .i_we    (w_ram_we),
        .i_waddr (r_wptr),
        .i_wdata (wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    // ------------------------------------------------------------------------
    // Pointers, level and sticky status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ram_we) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rptr_inc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level     <= r_level + {{ASIZE{1'b0}}, w_wr_ok}
                                   - {{ASIZE{1'b0}}, w_rd_ok};
            r_overflow  <= r_overflow  | (winc & w_full & ~w_rd_ok);
            r_underflow <= r_underflow | (rinc & w_empty);
        end
    end

    // ------------------------------------------------------------------------
    // Read-side datapath
    // ------------------------------------------------------------------------
    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            logic             r_out_valid;
            logic [DSIZE-1:0] r_out_data;
            logic             r_fwd_valid;
            logic [DSIZE-1:0] r_fwd_data;
            logic             w_ram_none;
            logic             w_bypass;
            logic             w_load;

            // level counts the output register too, so the RAM is empty
            // exactly when level equals the output register occupancy
            assign w_ram_none = (r_level == {{ASIZE{1'b0}}, r_out_valid});
            assign w_bypass   = w_wr_ok & (~r_out_valid | (w_rd_ok & w_ram_none));
            assign w_load     = w_rd_ok & ~w_ram_none;

            assign w_empty    = ~r_out_valid;
            assign w_ram_we   = w_wr_ok & ~w_bypass;
            assign w_rptr_inc = w_load;

            // The RAM read port is kept pointed at the entry behind the
            // head, so its registered output is ready when the head pops
            assign w_ram_re    = 1'b1;
            assign w_ram_raddr = r_rptr + {{(ASIZE-1){1'b0}}, w_load};

            always_ff @(posedge clk) begin
                if (w_flush) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_fwd_valid <= 1'b0;
                    r_fwd_data  <= '0;
                end else begin
                    // Writing the very address being read returns stale
                    // RAM data for one cycle; hold the new word aside
                    r_fwd_valid <= w_ram_we & (r_wptr == w_ram_raddr);
                    r_fwd_data  <= wdata;
                    if (w_bypass) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= wdata;
                    end else if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_fwd_valid ? r_fwd_data : w_ram_q;
                    end else if (w_rd_ok) begin
                        r_out_valid <= 1'b0;
                    end
                end
            end

            assign rdata  = r_out_data;
            assign rvalid = r_out_valid;
        end else begin : g_std
            logic r_rvalid;

            assign w_empty     = (r_level == '0);
            assign w_ram_we    = w_wr_ok;
            assign w_ram_re    = w_rd_ok;
            assign w_ram_raddr = r_rptr;
            assign w_rptr_inc  = w_rd_ok;

            always_ff @(posedge clk) begin
                if (w_flush) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_ok;
                end
            end

            assign rdata  = w_ram_q;
            assign rvalid = r_rvalid;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Flag decode (registered state only)
    // ------------------------------------------------------------------------
    assign wfull         = w_full;
    assign walmost_full  = (r_level >= C_AF_LVL);
    assign rempty        = w_empty;
    assign ralmost_empty = (r_level <= C_AE_LVL);
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule : fifo_sync_fwft
`default_nettype wire
